// File: rtl/switch_arbiter.sv
// switch_arbiter
//   Central output-allocation arbiter for the 4-port switch. Each cycle it
//   matches waiting input ports to free outputs, using all-or-nothing
//   multicast and a round-robin start pointer. It registers a one-cycle grant
//   pulse per port, plus the per-output valid and mux select.
//
// Parameters
//   HOLDOFF  cycles a port is ineligible after a grant (0..7)
//   CNT_W    width of each per-port grant statistics counter
//
// Ports
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   en         arbitration enable (0: no new grants, pointer frozen)
//   req_valid  [3:0]  port i head packet waiting
//   req_dst    [15:0] port i destination set at [4i+3:4i]
//   grant      [3:0]  one-cycle grant pulse per port
//   out_valid  [3:0]  output j carries a packet this cycle
//   out_sel    [7:0]  [2j+1:2j] = input port driving output j
//   grant_cnt  [4*CNT_W-1:0] per-port grant counters
//
// Build option
//   SW_ARB_STATS_EN : build saturating per-port grant counters; otherwise
//                     grant_cnt is tied to 0. Arbitration is identical.

// Per-port holdoff timer: loaded on grant, counts down to 0.
module switch_arbiter_lane #(
  parameter int HOLDOFF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_set,
  output logic hold_free
);
  logic [2:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                hold_cnt <= '0;
    else if (grant_set)        hold_cnt <= 3'(HOLDOFF);
    else if (hold_cnt != '0)   hold_cnt <= hold_cnt - 3'd1;
  end

  assign hold_free = (hold_cnt == '0);
endmodule

module switch_arbiter #(
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [3:0]         req_valid,
  input  logic [15:0]        req_dst,
  output logic [3:0]         grant,
  output logic [3:0]         out_valid,
  output logic [7:0]         out_sel,
  output logic [4*CNT_W-1:0] grant_cnt
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  logic [NUM_LANES-1:0][VEC_W-1:0] dst;
  logic [NUM_LANES-1:0]            hold_free;
  logic [NUM_LANES-1:0]            elig;
  logic [NUM_LANES-1:0]            gnt_nxt;
  logic [VEC_W-1:0]                alloc;
  logic [VEC_W-1:0][1:0]           sel_nxt;
  logic [1:0]                      rr_ptr;
  logic [1:0]                      ptr_nxt;
  logic [1:0]                      idx;
  logic                            first_found;

  assign dst = req_dst;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      switch_arbiter_lane #(.HOLDOFF(HOLDOFF)) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant_set (gnt_nxt[gi]),
        .hold_free (hold_free[gi])
      );
      assign elig[gi] = en & req_valid[gi] & (|dst[gi]) & hold_free[gi];
    end
  endgenerate

  // Greedy allocation in round-robin order. An earlier port's claim is never
  // undone, and a multicast port wins only if its whole set is still free.
  // Outputs not claimed this cycle keep their previous select.
  always_comb begin
    alloc       = '0;
    gnt_nxt     = '0;
    sel_nxt     = out_sel;
    ptr_nxt     = rr_ptr;
    first_found = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = rr_ptr + 2'(k);
      if (elig[idx] && ((dst[idx] & alloc) == '0)) begin
        gnt_nxt[idx] = 1'b1;
        alloc        = alloc | dst[idx];
        for (int j = 0; j < VEC_W; j++)
          if (dst[idx][j]) sel_nxt[j] = idx;
        // Pointer moves past the first winner, so an eligible port sitting
        // at the pointer is always served.
        if (!first_found) begin
          first_found = 1'b1;
          ptr_nxt     = idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      out_valid <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else begin
      grant     <= gnt_nxt;
      out_valid <= alloc;
      out_sel   <= sel_nxt;
      rr_ptr    <= ptr_nxt;
    end
  end

`ifdef SW_ARB_STATS_EN
  logic [NUM_LANES-1:0][CNT_W-1:0] stat;

  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_stat
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          stat[gi] <= '0;
        else if (grant[gi] && stat[gi] != '1) stat[gi] <= stat[gi] + 1'b1;
      end
    end
  endgenerate

  assign grant_cnt = stat;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter (HOLDOFF=2, CNT_W=8). Inputs change 1ns
// after a rising edge, and outputs are checked 1ns after the next rising edge.
module tb_switch_arbiter;
  localparam int CNT_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [3:0]         req_valid = '0;
  logic [15:0]        req_dst = '0;
  logic [3:0]         grant;
  logic [3:0]         out_valid;
  logic [7:0]         out_sel;
  logic [4*CNT_W-1:0] grant_cnt;

  int checks = 0;
  int failures = 0;

  switch_arbiter #(.HOLDOFF(2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_dst   (req_dst),
    .grant     (grant),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] v,
                         input logic [7:0] s);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_sel"}, 32'(out_sel), 32'(s));
  endtask

  initial begin
    // Reset state
    tick(2);
    chk_out("reset", 4'h0, 4'h0, 8'h00);
    chk("reset.rr_ptr", 32'(dut.rr_ptr), 32'd0);
    chk("reset.grant_cnt", grant_cnt, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // 1 Unicast p0 -> out2
    req_valid = 4'b0001; req_dst = 16'h0004;
    tick();
    chk_out("uni", 4'b0001, 4'b0100, 8'h00);
    chk("uni.rr_ptr", 32'(dut.rr_ptr), 32'd1);
    req_valid = '0;
    tick();
    chk_out("uni.drop", 4'b0000, 4'b0000, 8'h00);
    tick(2);

    // 2 Contention on out0, pointer starts at 1
    req_valid = 4'b0111; req_dst = 16'h0111;
    tick(); chk_out("cont1", 4'b0010, 4'b0001, 8'h01);
    tick(); chk_out("cont2", 4'b0100, 4'b0001, 8'h02);
    tick(); chk_out("cont3", 4'b0001, 4'b0001, 8'h00);
    tick(); chk_out("cont4", 4'b0010, 4'b0001, 8'h01);
    chk("cont.rr_ptr", 32'(dut.rr_ptr), 32'd2);
    req_valid = '0;
    tick(3);

    // 3 Disjoint unicasts, all granted together; out2 keeps old select
    req_valid = 4'b1011; req_dst = 16'h8021;
    tick(); chk_out("disj", 4'b1011, 4'b1011, 8'hC4);
    chk("disj.rr_ptr", 32'(dut.rr_ptr), 32'd0);
    req_valid = '0;
    tick(3);

    // 4 Broadcast at top priority blocks p1, p1 follows next cycle
    req_valid = 4'b0011; req_dst = 16'h002F;
    tick(); chk_out("mc", 4'b0001, 4'b1111, 8'h00);
    req_valid = 4'b0010;
    tick(); chk_out("mc.next", 4'b0010, 4'b0010, 8'h04);
    chk("mc.rr_ptr", 32'(dut.rr_ptr), 32'd2);
    req_valid = '0;
    tick(3);

    // 5 Empty destination never granted; en low freezes everything
    req_valid = 4'b0100; req_dst = 16'h0000;
    tick(2); chk_out("nulldst", 4'b0000, 4'b0000, 8'h04);
    en = 1'b0; req_valid = 4'b0011; req_dst = 16'h0021;
    tick(); chk_out("en0", 4'b0000, 4'b0000, 8'h04);
    chk("en0.rr_ptr", 32'(dut.rr_ptr), 32'd2);
    en = 1'b1;
    tick(); chk_out("en1", 4'b0011, 4'b0011, 8'h04);
    en = 1'b0;
    tick(); chk_out("enfall", 4'b0000, 4'b0000, 8'h04);
    chk("enfall.rr_ptr", 32'(dut.rr_ptr), 32'd1);
    en = 1'b1; req_valid = '0;
    tick(3);

    // 6 Reset mid-grant drops outputs asynchronously
    req_valid = 4'b0100; req_dst = 16'h0100;
    tick(); chk_out("rstmid.pre", 4'b0100, 4'b0001, 8'h06);
    #2 rst_n = 1'b0;
    #1 chk_out("rstmid", 4'b0000, 4'b0000, 8'h00);
    chk("rstmid.rr_ptr", 32'(dut.rr_ptr), 32'd0);
    req_valid = '0;
    #1 rst_n = 1'b1;
    tick(); chk_out("rstmid.post", 4'b0000, 4'b0000, 8'h00);

    // Sustained p0 requests: one grant every 3 cycles, ~333 grants
    req_valid = 4'b0001; req_dst = 16'h0001;
    tick(1000);
    req_valid = '0;
    tick(3);
`ifdef SW_ARB_STATS_EN
    chk("stats.p0", 32'(grant_cnt[CNT_W-1:0]), 32'd255);
    chk("stats.p1", 32'(grant_cnt[2*CNT_W-1:CNT_W]), 32'd0);
`else
    chk("stats.off", grant_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
